// File: rtl/keypad_if.sv
// Keypad encoder port bundle: raw key lines in, debounced key events out.
interface keypad_if #(
  parameter int N_KEYS = 10,
  parameter int CODE_W = 4
);
  logic [N_KEYS-1:0] keys;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_held;
  logic              key_release;
  logic              multi_key;

  modport master (
    input  keys,
    output key_valid,
    output key_code,
    output key_held,
    output key_release,
    output multi_key
  );

  modport slave (
    output keys,
    input  key_valid,
    input  key_code,
    input  key_held,
    input  key_release,
    input  multi_key
  );
endinterface

// File: rtl/keypad_debounce_encoder.sv
// Synchronises and debounces a one-hot keypad, rejects chords,
// and emits key events with optional auto-repeat.
module keypad_debounce_encoder #(
  parameter int N_KEYS          = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam logic [7:0]        DC  = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0]       RC  = 16'(REPEAT_CYCLES);
  localparam logic [N_KEYS-1:0] ONE = N_KEYS'(1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } st_t;

  st_t               st;
  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] ks;
  logic [N_KEYS-1:0] cap;
  logic [7:0]        dcnt;
  logic [15:0]       rcnt;
  logic              nz;
  logic              multi;
  logic              onehot;

  // clearing the lowest set bit leaves nonzero only for chords
  assign nz     = |ks;
  assign multi  = nz && |(ks & (ks - ONE));
  assign onehot = nz && !multi;

  function automatic logic [CODE_W-1:0] idx(
    input logic [N_KEYS-1:0] v
  );
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (v[i]) r = CODE_W'(i);
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st             <= IDLE;
      s1             <= '0;
      ks             <= '0;
      cap            <= '0;
      dcnt           <= '0;
      rcnt           <= '0;
      kp.key_valid   <= 1'b0;
      kp.key_code    <= '0;
      kp.key_held    <= 1'b0;
      kp.key_release <= 1'b0;
      kp.multi_key   <= 1'b0;
    end else begin
      s1             <= kp.keys;
      ks             <= s1;
      kp.multi_key   <= multi;
      kp.key_valid   <= 1'b0;
      kp.key_release <= 1'b0;
      unique case (st)
        IDLE: begin
          if (onehot) begin
            cap  <= ks;
            dcnt <= 8'd1;
            st   <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (ks == cap) begin
            if (dcnt + 8'd1 == DC) begin
              kp.key_valid <= 1'b1;
              kp.key_code  <= idx(cap);
              kp.key_held  <= 1'b1;
              rcnt         <= '0;
              dcnt         <= '0;
              st           <= PRESSED;
            end else begin
              dcnt <= dcnt + 8'd1;
            end
          end else begin
            dcnt <= '0;
            st   <= IDLE;
          end
        end
        PRESSED: begin
          if (ks == cap) begin
            if (RC != 16'd0) begin
              if (rcnt + 16'd1 == RC) begin
                kp.key_valid <= 1'b1;
                rcnt         <= '0;
              end else begin
                rcnt <= rcnt + 16'd1;
              end
            end
          end else begin
            dcnt <= nz ? 8'd0 : 8'd1;
            st   <= RELEASE;
          end
        end
        RELEASE: begin
          // any key activity restarts the release window
          if (!nz) begin
            if (dcnt + 8'd1 == DC) begin
              kp.key_release <= 1'b1;
              kp.key_held    <= 1'b0;
              dcnt           <= '0;
              st             <= IDLE;
            end else begin
              dcnt <= dcnt + 8'd1;
            end
          end else begin
            dcnt <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Scoreboard bench: two encoders (no repeat / repeat every 8),
// directed key stimulus, events checked by a negedge monitor.
module tb_keypad_debounce_encoder;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    bit         rel;
    logic [3:0] code;
    int         at;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  keypad_if #(.N_KEYS(10), .CODE_W(4)) a ();
  keypad_if #(.N_KEYS(10), .CODE_W(4)) b ();

  keypad_debounce_encoder #(
    .N_KEYS(10), .CODE_W(4),
    .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .kp(a.master)
  );

  keypad_debounce_encoder #(
    .N_KEYS(10), .CODE_W(4),
    .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)
  ) dut1 (
    .clk(clk), .rst(rst), .kp(b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int which, input bit rel,
                      input int code, input int at);
    ev_t e;
    e.rel  = rel;
    e.code = 4'(code);
    e.at   = at;
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  task automatic mon(input int which, input bit v, input bit r,
                     input logic [3:0] code);
    ev_t e;
    if (!(v || r)) return;
    check($sformatf("dut%0d_valid_and_release", which),
          int'(v && r), 0);
    if (which == 0 && q0.size() == 0 ||
        which == 1 && q1.size() == 0) begin
      check($sformatf("dut%0d_unexpected_event_rel", which),
            int'(r), -1);
      return;
    end
    e = (which == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("dut%0d_event_kind", which), int'(r), int'(e.rel));
    check($sformatf("dut%0d_event_code", which), int'(code), int'(e.code));
    check($sformatf("dut%0d_event_cycle", which), cyc, e.at);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, a.key_valid, a.key_release, a.key_code);
      mon(1, b.key_valid, b.key_release, b.key_code);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    a.keys = '0;
    b.keys = '0;
    step(3);
    check("rst_valid",   int'(a.key_valid),   0);
    check("rst_code",    int'(a.key_code),    0);
    check("rst_held",    int'(a.key_held),    0);
    check("rst_release", int'(a.key_release), 0);
    check("rst_multi",   int'(a.multi_key),   0);
    rst = 1'b0;
    step(2);

    // basic press of key 0 and release
    a.keys = 10'b1;
    c = cyc;
    push(0, 0, 0, c + 6);
    step(20);
    check("k0_held", int'(a.key_held), 1);
    check("k0_code", int'(a.key_code), 0);
    a.keys = '0;
    c = cyc;
    push(0, 1, 0, c + 6);
    step(8);
    check("k0_released_held", int'(a.key_held), 0);

    // 3-cycle glitch on key 9 is ignored, 10-cycle press is accepted
    a.keys = 10'b1 << 9;
    step(3);
    a.keys = '0;
    step(8);
    check("glitch_held", int'(a.key_held), 0);
    a.keys = 10'b1 << 9;
    c = cyc;
    push(0, 0, 9, c + 6);
    step(10);
    check("k9_code", int'(a.key_code), 9);
    a.keys = '0;
    c = cyc;
    push(0, 1, 9, c + 6);
    step(8);

    // chord rejected, then single key 0 after dropping key 1
    a.keys = 10'b11;
    step(2);
    check("multi_early", int'(a.multi_key), 0);
    step(1);
    check("multi_set", int'(a.multi_key), 1);
    step(3);
    check("multi_no_held", int'(a.key_held), 0);
    a.keys = 10'b1;
    c = cyc;
    push(0, 0, 0, c + 6);
    step(10);
    check("multi_cleared", int'(a.multi_key), 0);
    a.keys = '0;
    c = cyc;
    push(0, 1, 0, c + 6);
    step(8);

    // key 3 slides to key 7 without release: no new event
    a.keys = 10'b1 << 3;
    c = cyc;
    push(0, 0, 3, c + 6);
    step(10);
    a.keys = 10'b1 << 7;
    step(10);
    check("slide_held", int'(a.key_held), 1);
    check("slide_code", int'(a.key_code), 3);
    a.keys = '0;
    c = cyc;
    push(0, 1, 3, c + 6);
    step(8);
    a.keys = 10'b1 << 7;
    c = cyc;
    push(0, 0, 7, c + 6);
    step(10);
    a.keys = '0;
    c = cyc;
    push(0, 1, 7, c + 6);
    step(8);

    // auto-repeat every 8 cycles on key 5
    b.keys = 10'b1 << 5;
    c = cyc;
    for (int i = 0; i < 5; i++) push(1, 0, 5, c + 6 + 8 * i);
    step(40);
    check("rep_code", int'(b.key_code), 5);
    b.keys = '0;
    c = cyc;
    push(1, 1, 5, c + 6);
    step(10);

    // reset while debouncing key 2
    a.keys = 10'b1 << 2;
    step(4);
    #1 rst = 1'b1;
    #1;
    check("rstdb_code",  int'(a.key_code),  0);
    check("rstdb_valid", int'(a.key_valid), 0);
    step(2);
    rst = 1'b0;
    c = cyc;
    push(0, 0, 2, c + 6);
    step(10);
    check("post_rst_held", int'(a.key_held), 1);

    // reset while pressed: no release strobe, fresh debounce after
    #1 rst = 1'b1;
    #1;
    check("rstpr_held", int'(a.key_held), 0);
    check("rstpr_code", int'(a.key_code), 0);
    step(2);
    rst = 1'b0;
    c = cyc;
    push(0, 0, 2, c + 6);
    step(10);
    a.keys = '0;
    c = cyc;
    push(0, 1, 2, c + 6);
    step(10);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_debounce_encoder.md
Name: keypad_debounce_encoder

Overview:
Parametrised successor to the team's combinational keypad encoder. Synchronises a one-hot keypad vector, debounces it, and rejects multi-key chords. Emits a one-cycle key event carrying the binary key code, with optional auto-repeat while a key is held. Sits between the raw keypad pins and the BCD/display datapath.

Parameters:
N_KEYS, 10, number of keypad lines (2..32)
CODE_W, 4, key_code width; 2**CODE_W >= N_KEYS required
DEBOUNCE_CYCLES, 4, consecutive stable samples needed for press or release (2..255)
REPEAT_CYCLES, 0, auto-repeat period in cycles while held; 0 disables repeat (0..65535)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
keys  in  N_KEYS  raw keypad lines, bit i = key i pressed, asynchronous to clk
key_valid  out  1  one-cycle strobe: new or repeated key event
key_code  out  CODE_W  index of last accepted key; holds between events
key_held  out  1  level: a debounced key is down (PRESSED or RELEASE states)
key_release  out  1  one-cycle strobe: debounced release completed
multi_key  out  1  registered: synced keys had more than one bit set last cycle

Behaviour:
- Reset (async, rst=1): FSM=IDLE; sync flops, counters and captured one-hot = 0; all outputs 0.
- Input: 2-flop synchroniser per line; FSM sees ks = sync stage 2.
- Counters: dcnt 8-bit, rcnt 16-bit, no wrap (cleared on use).
- IDLE: ks exactly one bit set -> capture ks, dcnt=1, go DEBOUNCE. ks=0 or multi-bit -> stay.
- DEBOUNCE: ks==captured -> dcnt++; on the sample where dcnt reaches DEBOUNCE_CYCLES: key_valid=1, key_code=index(captured), rcnt=0, go PRESSED. ks!=captured (incl. 0 or multi) -> IDLE, dcnt=0, no event.
- PRESSED: key_held=1. ks==captured and REPEAT_CYCLES>0 -> rcnt++; when rcnt reaches REPEAT_CYCLES: key_valid=1 (same code), rcnt=0. ks!=captured (any value) -> RELEASE, dcnt=1 if ks==0 else 0.
- RELEASE: key_held=1, no repeats. ks==0 -> dcnt++; when dcnt reaches DEBOUNCE_CYCLES: key_release=1, key_held=0, go IDLE. ks!=0 -> dcnt=0, stay (must fully release before next press; returning to the same key does not re-trigger).
- Latency: keys stable from before edge 1 -> key_valid high after edge DEBOUNCE_CYCLES+2, for exactly one cycle.
- key_valid and key_release never assert in the same cycle. key_code updates only with key_valid.
- multi_key = (popcount(ks) > 1), registered; independent of FSM state.
- Glitch shorter than DEBOUNCE_CYCLES samples: no key_valid, no state change beyond DEBOUNCE->IDLE.
- rst mid-operation: immediate return to reset values; no release strobe emitted.

Test Plan:
- D=4,R=0: reset, keys=0 -> all outputs 0; set keys[0]=1 held 20 cycles -> single key_valid at edge 6, key_code=0, key_held=1; clear -> key_release 6 edges after clear, key_held=0.
- D=4: keys[9]=1 for 3 cycles then 0 -> no key_valid, key_held stays 0; keys[9]=1 for 4+ cycles -> key_valid, key_code=9.
- keys[0]=1 and keys[1]=1 together -> multi_key=1 three edges later, no key_valid; drop keys[1] -> key_valid with key_code=0.
- D=4,R=8: hold keys[5] 40 cycles -> key_valid at edge 6 then every 8 cycles, key_code=5 each time; release stops repeats.
- In PRESSED with key 3, switch to key 7 without release -> no event; keys=0 for 4 samples -> key_release; then key 7 pressed -> key_valid, key_code=7.
- Assert rst during DEBOUNCE and during PRESSED -> outputs 0 asynchronously; after rst release with key still held -> fresh debounce, key_valid after D+2 edges.
